// File: rtl/gf2m_bus_adapter_pkg.sv
// gf2m_pkg: shared widths, word counts and FSM state encoding for the GF(2^m) bus adapter
package gf2m_pkg;
  localparam int DATA_WIDTH = 163;
  localparam int DIGITAL = 32;
  localparam int WORDS = (DATA_WIDTH + DIGITAL - 1) / DIGITAL;
  localparam int BWIDTH = (DATA_WIDTH / DIGITAL + 1) * DIGITAL;
  localparam int OP_WORDS = 3 * WORDS;
  localparam int TIMEOUT_CYCLES = 1024;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_UNLOAD, S_CLEAR} state_t;
endpackage

// File: rtl/gf2m_bus_adapter_if.sv
// gf2m_bus_adapter_if: 32-bit operand-in / result-out stream handshake bundle
// slave: adapter side (accepts in_*, produces out_*); master: environment side
interface gf2m_bus_adapter_if;
  logic in_valid;
  logic in_ready;
  logic [31:0] in_data;
  logic out_valid;
  logic out_ready;
  logic [31:0] out_data;
  logic out_last;
  modport slave (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data, out_last);
  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data, out_last);
endinterface

// File: rtl/gf2m_bus_adapter_packer.sv
// gf2m_word_packer: inserts a 32-bit word at word index idx into a DATA_WIDTH register
// ports: clk, rst (sync, active-high), clr (zero), wr_en + idx + data (insert), value (register)
// bits of a word that land above DATA_WIDTH are dropped by the width truncation of the shift
module gf2m_word_packer
  import gf2m_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [2:0]            idx,
  input  logic [31:0]           data,
  output logic [DATA_WIDTH-1:0] value
);
  logic [DATA_WIDTH-1:0] value_q, value_d, mask, ins;
  logic [7:0] sh;
  always_comb begin
    sh = {idx, 5'd0};
    mask = DATA_WIDTH'(32'hFFFF_FFFF) << sh;
    ins = DATA_WIDTH'(data) << sh;
    value_d = clr ? '0 : wr_en ? ((value_q & ~mask) | ins) : value_q;
  end
  always_ff @(posedge clk) value_q <= rst ? '0 : value_d;
  assign value = value_q;
endmodule

// File: rtl/gf2m_bus_adapter.sv
// gf2m_bus_adapter: packs 32-bit operand words for the GF(2^m) multiplier and streams the result back
// ports: clk, rst (sync, active-high), bus (stream interface, slave), core_* (multiplier side), err
// optional: GF2M_TIMEOUT_EN adds a WAIT watchdog that sets sticky err and abandons the operation
module gf2m_bus_adapter
  import gf2m_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  gf2m_bus_adapter_if.slave     bus,
  output logic                  core_rst_n,
  output logic                  core_start,
  output logic [DATA_WIDTH-1:0] core_a,
  output logic [DATA_WIDTH-1:0] core_g,
  output logic [BWIDTH-1:0]     core_b,
  input  logic [DATA_WIDTH-1:0] core_t,
  input  logic                  core_done,
  output logic                  err
);
  state_t state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] res_q, res_d, b_val;
  logic core_rst_n_q, core_rst_n_d;
  logic in_fire, out_fire;
  logic [1:0] op;
  logic [2:0] idx;
`ifdef GF2M_TIMEOUT_EN
  logic [15:0] tmo_q, tmo_d;
  logic err_q, err_d;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      res_q <= '0;
      core_rst_n_q <= 1'b0;
`ifdef GF2M_TIMEOUT_EN
      tmo_q <= '0;
      err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      res_q <= res_d;
      core_rst_n_q <= core_rst_n_d;
`ifdef GF2M_TIMEOUT_EN
      tmo_q <= tmo_d;
      err_q <= err_d;
`endif
    end
  end
  always_comb begin
    in_fire = bus.in_valid && state_q == S_LOAD;
    out_fire = bus.out_ready && state_q == S_UNLOAD;
    state_d = state_q;
    cnt_d = cnt_q;
    res_d = res_q;
`ifdef GF2M_TIMEOUT_EN
    err_d = err_q;
    tmo_d = state_q == S_WAIT ? tmo_q + 16'd1 : '0;
`endif
    case (state_q)
      S_IDLE: begin
        state_d = S_LOAD;
        cnt_d = '0;
      end
      S_LOAD: if (in_fire) begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(OP_WORDS - 1)) state_d = S_START;
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (core_done) begin
          res_d = core_t;
          cnt_d = '0;
          state_d = S_UNLOAD;
        end
`ifdef GF2M_TIMEOUT_EN
        else if (tmo_q == 16'(TIMEOUT_CYCLES - 1)) begin
          err_d = 1'b1;
          state_d = S_CLEAR;
        end
`endif
      end
      S_UNLOAD: if (out_fire) begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(WORDS - 1)) state_d = S_CLEAR;
      end
      S_CLEAR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // registered so the core stays in reset for the whole rst window and exactly one CLEAR cycle
    core_rst_n_d = state_d != S_CLEAR;
  end
  always_comb begin
    op = cnt_q < 5'(WORDS) ? 2'd0 : cnt_q < 5'(2 * WORDS) ? 2'd1 : 2'd2;
    idx = 3'(cnt_q - (op == 2'd2 ? 5'(2 * WORDS) : op == 2'd1 ? 5'(WORDS) : 5'd0));
    bus.in_ready = state_q == S_LOAD;
    bus.out_valid = state_q == S_UNLOAD;
    bus.out_last = state_q == S_UNLOAD && cnt_q == 5'(WORDS - 1);
    bus.out_data = 32'(res_q >> {cnt_q[2:0], 5'd0});
    core_start = state_q == S_START;
    core_rst_n = core_rst_n_q;
  end
`ifdef GF2M_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif
  gf2m_word_packer u_pack_a (.clk(clk), .rst(rst), .clr(state_q == S_CLEAR), .wr_en(in_fire && op == 2'd0), .idx(idx), .data(bus.in_data), .value(core_a));
  gf2m_word_packer u_pack_g (.clk(clk), .rst(rst), .clr(state_q == S_CLEAR), .wr_en(in_fire && op == 2'd1), .idx(idx), .data(bus.in_data), .value(core_g));
  gf2m_word_packer u_pack_b (.clk(clk), .rst(rst), .clr(state_q == S_CLEAR), .wr_en(in_fire && op == 2'd2), .idx(idx), .data(bus.in_data), .value(b_val));
  // the core consumes b MSB digit first, so the spare digit sits zeroed at the top
  assign core_b = BWIDTH'(b_val);
endmodule

// File: tb/tb_gf2m_bus_adapter.sv
// tb_gf2m_bus_adapter: scoreboard bench with a behavioural GF(2^163) core and reference multiply
module tb_gf2m_bus_adapter;
  import gf2m_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  gf2m_bus_adapter_if bus();
  logic core_rst_n, core_start, core_done, err;
  logic [162:0] core_a, core_g, core_t;
  logic [191:0] core_b;
  gf2m_bus_adapter dut (.clk(clk), .rst(rst), .bus(bus), .core_rst_n(core_rst_n), .core_start(core_start),
    .core_a(core_a), .core_g(core_g), .core_b(core_b), .core_t(core_t), .core_done(core_done), .err(err));
  typedef struct {logic [31:0] d; logic l;} word_t;
  typedef struct {logic [162:0] a; logic [162:0] g; logic [162:0] b;} op_t;
  word_t exp_q[$];
  op_t op_q[$];
  int checks = 0;
  int failures = 0;
  int clears = 0;
  int nops = 0;
  int lowrun = 0;
  bit armed, held, stall_en, gaps, core_hold;
  logic [31:0] hold_d;
  word_t w;
  op_t o;
  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // reference: LSB-first shift-and-add with x^163 + g reduction
  function automatic logic [162:0] gf_mul(input logic [162:0] a, input logic [162:0] b, input logic [162:0] g);
    logic [163:0] aa = {1'b0, a};
    logic [162:0] r = '0;
    for (int i = 0; i < 163; i++) begin
      if (b[i]) r ^= aa[162:0];
      aa = aa << 1;
      if (aa[163]) aa ^= {1'b1, g};
    end
    return r;
  endfunction
  // core stand-in: MSB-first Horner evaluation, a different route to the same product
  function automatic logic [162:0] core_mul(input logic [162:0] a, input logic [162:0] b, input logic [162:0] g);
    logic [163:0] r = '0;
    for (int i = 162; i >= 0; i--) begin
      r = r << 1;
      if (r[163]) r ^= {1'b1, g};
      if (b[i]) r ^= {1'b0, a};
    end
    return r[162:0];
  endfunction
  initial begin
    int lat = 0;
    logic [162:0] pend;
    core_done = 1'b0;
    core_t = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!core_rst_n) begin
        core_done = 1'b0;
        lat = 0;
      end else if (lat > 0) begin
        lat--;
        if (lat == 0) begin
          core_done = 1'b1;
          core_t = pend;
        end
      end else if (core_start && !core_hold && !core_done) begin
        lat = $urandom_range(3, 9);
        pend = core_mul(core_a, core_b[162:0], core_g);
      end
    end
  end
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end
  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
      armed = 1'b0;
      lowrun = 0;
    end else begin
      if (bus.out_valid) begin
        if (held) chk("out_stable", bus.out_data, hold_d);
        if (bus.out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_out: got %0h expected no word", bus.out_data);
          end else begin
            w = exp_q.pop_front();
            chk("out_data", bus.out_data, w.d);
            chk("out_last", bus.out_last, w.l);
          end
          held = 1'b0;
        end else begin
          held = 1'b1;
          hold_d = bus.out_data;
        end
      end else held = 1'b0;
      if (core_start) begin
        if (op_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_start: got start expected none");
        end else begin
          o = op_q.pop_front();
          chk("core_a", core_a, o.a);
          chk("core_g", core_g, o.g);
          chk("core_b", core_b, {29'b0, o.b});
        end
      end
      if (core_rst_n) begin
        if (armed && lowrun > 0) begin
          chk("clear_len", lowrun, 1);
          clears++;
        end
        armed = 1'b1;
        lowrun = 0;
      end else if (armed) lowrun++;
    end
  end
  task automatic send_word(input logic [31:0] d);
    int n = 0;
    bit done = 1'b0;
    if (gaps) repeat ($urandom_range(0, 2)) begin
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b1;
    bus.in_data = d;
    while (!done && n < 400) begin
      @(negedge clk);
      if (bus.in_ready) done = 1'b1;
      else n++;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL in_ready_timeout: got no in_ready expected in_ready within 400 cycles");
    end
  endtask
  task automatic run_op(input logic [191:0] ra, input logic [191:0] rg, input logic [191:0] rb, input bit expect_res);
    op_t x;
    logic [575:0] all = {rb, rg, ra};
    logic [191:0] rp;
    x.a = ra[162:0];
    x.g = rg[162:0];
    x.b = rb[162:0];
    op_q.push_back(x);
    nops++;
    if (expect_res) begin
      word_t e;
      rp = {29'b0, gf_mul(x.a, x.b, x.g)};
      for (int k = 0; k < 6; k++) begin
        e.d = rp[32*k +: 32];
        e.l = (k == 5);
        exp_q.push_back(e);
      end
    end
    for (int k = 0; k < 18; k++) send_word(all[32*k +: 32]);
  endtask
  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain: got %0d words pending expected 0", exp_q.size());
    end
  endtask
  function automatic logic [191:0] rnd192();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction
  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    stall_en = 1'b0;
    gaps = 1'b0;
    core_hold = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_core_rst_n", core_rst_n, 0);
    chk("rst_core_start", core_start, 0);
    chk("rst_core_a", core_a, 0);
    chk("rst_core_g", core_g, 0);
    chk("rst_core_b", core_b, 0);
    chk("rst_err", err, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_core_rst_n", core_rst_n, 1);
    chk("post_rst_in_ready", bus.in_ready, 1);
    run_op(192'h1, 192'hC9, 192'h4, 1'b1);
    drain();
    run_op({32'hFFFF_FFFF, rnd192() >> 32}, rnd192(), rnd192(), 1'b1);
    drain();
    stall_en = 1'b1;
    gaps = 1'b1;
    for (int i = 0; i < 6; i++) run_op(rnd192(), rnd192(), rnd192(), 1'b1);
    drain();
    stall_en = 1'b0;
    gaps = 1'b0;
    for (int k = 0; k < 7; k++) send_word($urandom());
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("abort_core_rst_n", core_rst_n, 0);
    chk("abort_in_ready", bus.in_ready, 0);
    chk("abort_core_a", core_a, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_op(rnd192(), rnd192(), rnd192(), 1'b1);
    drain();
`ifdef GF2M_TIMEOUT_EN
    begin
      int n = 0;
      core_hold = 1'b1;
      run_op(rnd192(), rnd192(), rnd192(), 1'b0);
      while (!err && n < 1200) begin
        @(negedge clk);
        if (!err) n++;
      end
      chk("timeout_err", err, 1);
      chk("timeout_len", n, 1025);
      n = 0;
      while (!bus.in_ready && n < 10) begin
        @(negedge clk);
        n++;
      end
      chk("timeout_back_to_load", bus.in_ready, 1);
      core_hold = 1'b0;
    end
`endif
    repeat (6) @(posedge clk);
    chk("clear_count", clears, nops);
`ifdef GF2M_TIMEOUT_EN
    chk("final_err", err, 1);
`else
    chk("final_err", err, 0);
`endif
    chk("ops_started", op_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
